rr_mux_arbiter: RTL and testbench
=================================

Name: rr_mux_arbiter

Overview:
- Shares one N:1 data multiplexer and one output register among N requesters, using round-robin arbitration.
- Each requester presents a W-bit word with a request.
- The arbiter picks one requester per cycle, steers its word through the shared mux into the output register, and returns a one-cycle grant.
- Sits between independent producers and a single downstream consumer that has valid/ready flow control.

Parameters:
- N, default 4: number of requesters; N ≥ 2.
- W, default 8: data word width in bits.
- IW, default $clog2(N): index width; derived, not overridden.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-high.
- req  input  N  req[i]=1: requester i has a word pending.
- data  input  N*W  flattened words; requester i at data[i*W +: W].
- gnt  output  N  one-hot or zero; gnt[i]=1 means requester i's word is taken this cycle.
- out_valid  output  1  output register holds a word.
- out_ready  input  1  consumer accepts the word this cycle.
- out_data  output  W  registered word.
- out_src  output  IW  index of the requester that supplied out_data.

Behaviour:
- Reset: out_valid=0, out_data=0, out_src=0, internal last-grant pointer last=N-1, so index 0 has top priority first. gnt=0 while rst=1.
- Reset asserted mid-operation discards any held word; no grant is issued in a reset cycle.
- Slot free: free = !out_valid || out_ready. Output register is a 1-deep pipeline stage; a new word may enter in the same cycle the old one leaves.
- gnt is combinational from req, last, out_valid, out_ready and rst.
  - When free=1 and req≠0: gnt has exactly one bit set, the first i with req[i]=1, searching last+1, last+2, … modulo N (wraps N-1 → 0).
  - Otherwise gnt=0.
- On the rising edge with gnt[k]=1:
  - out_data ← data[k*W +: W] (shared mux with select = k).
  - out_src ← k.
  - out_valid ← 1.
  - last ← k.
- On the rising edge with free=1 and no grant: out_valid ← (out_valid && !out_ready); out_data and out_src hold their values.
- When out_valid=1 and out_ready=0: out_data, out_src, out_valid and last hold; gnt=0 (backpressure).
- Latency: a word granted in cycle t appears on out_data with out_valid=1 from cycle t+1.
- Throughput: one word per cycle while out_ready=1.
- Requester protocol: hold req=1 and data stable until the cycle gnt[i]=1. The word is consumed on that edge. Requester may deassert req next cycle or present a new word.
- Dropping req before grant is legal; no word is taken.
- Fairness: with all N requesting continuously and out_ready=1, grants rotate 0,1,…,N-1,0,… Each requester waits at most N-1 other grants.
- last changes only on a grant; an idle cycle does not move priority.
- Simultaneous events:
  - Grant and consumer accept in the same cycle: new word replaces old with no bubble.
  - A req rising in the same cycle as free rising is eligible that cycle.
- out_data width W exactly; no arithmetic.
- X on data of non-granted requesters must not propagate to out_data.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, req=0 → out_valid=0, out_data=0, out_src=0, gnt=0 for all cycles.
- Single requester, N=4, W=8: req=4'b0100, data[2]=8'hA5, out_ready=1 → gnt=4'b0100 in cycle t; out_data=8'hA5, out_src=2, out_valid=1 at t+1.
- Rotation and wrap: req=4'b1111 held, distinct data per port, out_ready=1 for 8 cycles → out_src sequence 0,1,2,3,0,1,2,3 on consecutive cycles with no bubbles.
- Backpressure: out_valid=1 holding 8'h11 from src 1, out_ready=0 for 3 cycles with req=4'b1010 → gnt=0, out_data=8'h11 stable. On out_ready=1 → gnt=4'b1000 the same cycle; next word from src 3.
- Skip and wrap: last=3 (after granting src 3), req=4'b0010 → gnt=4'b0010. Then req=4'b1001 → gnt=4'b1000 (3 is searched before 0 since last=1).
- Reset mid-stream: out_valid=1, out_ready=0, rst=1 for one cycle → out_valid=0, out_src=0. Next grant with req=4'b1111 goes to index 0.

Source files
------------

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter sharing one N:1 data mux and a single-entry output register
// among N requesters, with valid/ready flow control toward one consumer.
module rr_mux_arbiter #(
  parameter int N = 4,
  parameter int W = 8,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] data,
  output logic [N-1:0]   gnt,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   out_data,
  output logic [IW-1:0]  out_src
);

  logic [IW-1:0] last;
  logic [W-1:0]  data_p1;
  logic [IW-1:0] src_p1;
  logic          vld_p1;

  logic          free;
  logic          gnt_any;
  logic [IW-1:0] gnt_idx;
  int            idx;

  assign free = !vld_p1 || out_ready;

  // Search starts one past the last winner and wraps, so the previous winner is checked last.
  always_comb begin
    gnt     = '0;
    gnt_any = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    if (!rst && free) begin
      for (int off = 1; off <= N; off++) begin
        idx = (int'(last) + off) % N;
        if (!gnt_any && req[idx]) begin
          gnt_any = 1'b1;
          gnt_idx = IW'(idx);
        end
      end
    end
    if (gnt_any) gnt[gnt_idx] = 1'b1;
  end

  // Stage p0 -> p1: only the granted word is selected, so X on idle ports never reaches the register.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      src_p1  <= '0;
      last    <= IW'(N - 1);
    end else if (gnt_any) begin
      data_p1 <= data[gnt_idx*W +: W];
      src_p1  <= gnt_idx;
      vld_p1  <= 1'b1;
      last    <= gnt_idx;
    end else if (free) begin
      vld_p1  <= vld_p1 && !out_ready;
    end
  end

  assign out_valid = vld_p1;
  assign out_data  = data_p1;
  assign out_src   = src_p1;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed bench for rr_mux_arbiter (N=4, W=8) with hand-computed expectations.
module tb_rr_mux_arbiter;
  localparam int N  = 4;
  localparam int W  = 8;
  localparam int IW = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [N*W-1:0] data;
  logic [N-1:0]   gnt;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   out_data;
  logic [IW-1:0]  out_src;

  int total = 0;
  int bad   = 0;

  rr_mux_arbiter #(.N(N), .W(W)) dut (
    .clk(clk), .rst(rst), .req(req), .data(data), .gnt(gnt),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_src(out_src)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic v, input logic [W-1:0] d,
                           input logic [IW-1:0] s);
    check({tag, "_valid"}, 32'(out_valid), 32'(v));
    check({tag, "_data"},  32'(out_data),  32'(d));
    check({tag, "_src"},   32'(out_src),   32'(s));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req = '0; data = '0; out_ready = 1'b1;

    // Reset then idle
    tick;
    check_out("rst0", 1'b0, 8'h00, 2'd0);
    check("rst0_gnt", 32'(gnt), 32'h0);
    tick;
    check_out("rst1", 1'b0, 8'h00, 2'd0);
    req = 4'b1111;
    #1 check("rst_req_gnt", 32'(gnt), 32'h0);
    tick;
    check("rst2_valid", 32'(out_valid), 32'h0);

    // Single requester with X on the idle ports
    rst = 1'b0; req = 4'b0100;
    data = 'x;
    data[2*W +: W] = 8'hA5;
    #1 check("single_gnt", 32'(gnt), 32'b0100);
    tick;
    check_out("single", 1'b1, 8'hA5, 2'd2);
    req = '0;
    #1 check("idle_gnt", 32'(gnt), 32'h0);
    tick;
    check("drain_valid", 32'(out_valid), 32'h0);

    // Rotation and wrap from a fresh reset
    rst = 1'b1;
    tick;
    rst = 1'b0;
    data = {8'h33, 8'hC2, 8'h11, 8'hC0};
    req  = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      #1 check("rot_gnt", 32'(gnt), 32'(4'b0001 << (k % 4)));
      tick;
      check_out("rot", 1'b1, (k % 4 == 0) ? 8'hC0 : (k % 4 == 1) ? 8'h11 :
                             (k % 4 == 2) ? 8'hC2 : 8'h33, 2'(k % 4));
    end

    // Backpressure: hold 8'h11 from src 1
    req = 4'b0010;
    #1 check("bp_load_gnt", 32'(gnt), 32'b0010);
    tick;
    check_out("bp_load", 1'b1, 8'h11, 2'd1);
    out_ready = 1'b0; req = 4'b1010;
    for (int c = 0; c < 3; c++) begin
      #1 check("bp_gnt", 32'(gnt), 32'h0);
      tick;
      check_out("bp_hold", 1'b1, 8'h11, 2'd1);
    end
    out_ready = 1'b1;
    #1 check("bp_release_gnt", 32'(gnt), 32'b1000);
    tick;
    check_out("bp_next", 1'b1, 8'h33, 2'd3);

    // Skip and wrap
    req = 4'b0010;
    #1 check("skip_gnt", 32'(gnt), 32'b0010);
    tick;
    check_out("skip", 1'b1, 8'h11, 2'd1);
    req = 4'b1001;
    #1 check("wrap_gnt", 32'(gnt), 32'b1000);
    tick;
    check_out("wrap", 1'b1, 8'h33, 2'd3);

    // Reset mid-stream with a held word
    out_ready = 1'b0; req = '0;
    #1 check("mid_hold_gnt", 32'(gnt), 32'h0);
    rst = 1'b1;
    tick;
    check_out("mid_rst", 1'b0, 8'h00, 2'd0);
    rst = 1'b0; out_ready = 1'b1; req = 4'b1111;
    #1 check("post_rst_gnt", 32'(gnt), 32'b0001);
    tick;
    check_out("post_rst", 1'b1, 8'hC0, 2'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
